// File: rtl/key_schedule_gen.sv
// Iterative AES key expansion (128/192/256): one schedule word per clock, round keys
// streamed on a valid/ready port and kept in a readable local table.
module key_schedule_gen #(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic [KEY_BITS-1:0] key_in,
   output logic                busy,
   output logic                done,
   output logic                rk_valid,
   input  logic                rk_ready,
   output logic [3:0]          rk_index,
   output logic [127:0]        rk_data,
   input  logic [3:0]          rd_addr,
   output logic [127:0]        rd_data
);

   localparam int NK     = KEY_BITS / 32;
   localparam int NR     = NK + 6;
   localparam int LAST_I = 4 * NR + 3;

   generate
      if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
         $error("key_schedule_gen: KEY_BITS must be 128, 192 or 256");
      end
   endgenerate

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EXPAND = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box computed as x^254 (the field inverse, 0 maps to 0) followed by the AES affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] sq;
      inv = 8'h01;
      sq  = x;
      for (int k = 0; k < 7; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   logic [1:0]   state_q,    state_d;
   logic [5:0]   i_q,        i_d;
   logic [2:0]   j_q,        j_d;
   logic [7:0]   rcon_q,     rcon_d;
   logic [31:0]  win_q [NK];
   logic [31:0]  win_d [NK];
   logic         rk_valid_q, rk_valid_d;
   logic [3:0]   rk_index_q, rk_index_d;
   logic [127:0] rk_data_q,  rk_data_d;
   logic [127:0] tbl_q [NR+1];
   logic [127:0] tbl_d [NR+1];
   logic [127:0] rd_data_q,  rd_data_d;

   logic         advance;
   logic         accept;
   logic         hs;
   logic         key_done;
   logic [31:0]  sw_in;
   logic [31:0]  sw_out;
   logic [31:0]  new_w;
   logic [127:0] new_key;

   always_comb begin
      accept   = start && (state_q == S_IDLE || state_q == S_DONE);
      hs       = rk_valid_q && rk_ready;
      advance  = (state_q == S_EXPAND) && !(rk_valid_q && !rk_ready);
      key_done = advance && (i_q[1:0] == 2'b11);

      sw_in  = (j_q == 3'd0) ? {win_q[NK-1][23:0], win_q[NK-1][31:24]} : win_q[NK-1];
      sw_out = sub_word(sw_in);

      // During the first NK steps the window rotates, so its oldest slot is key word i.
      if (i_q < 6'(NK))
         new_w = win_q[0];
      else if (j_q == 3'd0)
         new_w = win_q[0] ^ sw_out ^ {rcon_q, 24'h0};
      else if (NK == 8 && j_q == 3'd4)
         new_w = win_q[0] ^ sw_out;
      else
         new_w = win_q[0] ^ win_q[NK-1];

      new_key = {win_q[NK-3], win_q[NK-2], win_q[NK-1], new_w};

      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      rcon_d     = rcon_q;
      win_d      = win_q;
      rk_valid_d = rk_valid_q;
      rk_index_d = rk_index_q;
      rk_data_d  = rk_data_q;
      tbl_d      = tbl_q;

      case (state_q)
         S_DRAIN: if (hs) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: ;
      endcase

      if (accept) begin
         state_d = S_EXPAND;
         i_d     = 6'd0;
         j_d     = 3'd0;
         rcon_d  = 8'h01;
         for (int k = 0; k < NK; k++) win_d[k] = key_in[KEY_BITS-1-32*k -: 32];
         for (int k = 0; k <= NR; k++) tbl_d[k] = '0;
      end

      if (advance) begin
         for (int k = 0; k < NK - 1; k++) win_d[k] = win_q[k+1];
         win_d[NK-1] = new_w;
         i_d = i_q + 6'd1;
         j_d = (j_q == 3'(NK - 1)) ? 3'd0 : j_q + 3'd1;
         if (i_q >= 6'(NK) && j_q == 3'd0) rcon_d = xtime(rcon_q);
         if (i_q == 6'(LAST_I)) state_d = S_DRAIN;
      end

      if (hs) rk_valid_d = 1'b0;
      if (key_done) begin
         rk_valid_d          = 1'b1;
         rk_index_d          = i_q[5:2];
         rk_data_d           = new_key;
         tbl_d[i_q[5:2]]     = new_key;
      end

      rd_data_d = (rd_addr <= 4'(NR)) ? tbl_q[rd_addr] : '0;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= S_IDLE;
         i_q        <= '0;
         j_q        <= '0;
         rcon_q     <= '0;
         rk_valid_q <= 1'b0;
         rk_index_q <= '0;
         rk_data_q  <= '0;
         rd_data_q  <= '0;
         for (int k = 0; k < NK; k++) win_q[k] <= '0;
         for (int k = 0; k <= NR; k++) tbl_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         j_q        <= j_d;
         rcon_q     <= rcon_d;
         rk_valid_q <= rk_valid_d;
         rk_index_q <= rk_index_d;
         rk_data_q  <= rk_data_d;
         rd_data_q  <= rd_data_d;
         win_q      <= win_d;
         tbl_q      <= tbl_d;
      end
   end

   assign busy     = (state_q == S_EXPAND) || (state_q == S_DRAIN);
   assign done     = (state_q == S_DONE);
   assign rk_valid = rk_valid_q;
   assign rk_index = rk_index_q;
   assign rk_data  = rk_data_q;
   assign rd_data  = rd_data_q;

endmodule
